int_arbiter: RTL and testbench
==============================

// Module: int_arbiter
// PURPOSE
// - Collects NUM_SRC machine-level interrupt lines, latches them as pending, masks with csr_mie, and presents exactly one
//   winner to clint as one-hot int_flag_o plus the mcause value int_cause_o.
// - Sits between the interrupt sources (timer, software, external pins) and clint.
// - Enforces no nesting: after clint acks, no new request is issued until mret_i.
// PARAMETERS
// - NUM_SRC     4      number of interrupt sources, 1..8; source i drives int_flag_o bit i.
// - EDGE_MASK   4'b0001 per-source bit: 1 = rising-edge triggered, 0 = level triggered.
// - CAUSE_BASE  16     mcause code of source 0; source i gets CAUSE_BASE+i; CAUSE_BASE+NUM_SRC must be <= 32.
// PORTS
// - clk               in   1        core clock
// - rst               in   1        synchronous, active-high reset
// - irq_i             in   NUM_SRC  raw interrupt lines, synchronous to clk
// - csr_mie           in   32       mie CSR; bit CAUSE_BASE+i enables source i
// - global_int_en_i   in   1        mstatus.MIE
// - int_ack_i         in   1        clint took the interrupt: one-cycle pulse when it leaves idle for an async interrupt
// - mret_i            in   1        one-cycle pulse, mret retired; handler done
// - int_flag_o        out  8        `INT_BUS one-hot winner; `INT_NONE when no request
// - int_cause_o       out  32       {1'b1, 26'b0, 5'(CAUSE_BASE+winner)}; 0 when no request
// - int_pending_o     out  NUM_SRC  pending bitmap, for a read-only mip view
// BEHAVIOUR
// - Reset: state=S_ARB_IDLE; pending=0; edge history=0; int_flag_o=0; int_cause_o=0; int_pending_o=0; rr pointer=0.
// - Capture, every cycle:
//   - edge source: pending set on irq_i 0->1 (previous-cycle register);
//   - level source: pending follows irq_i, except a held winner stays pending.
// - Eligible = pending & mie bits [CAUSE_BASE+:NUM_SRC].
// - FSM, registered outputs (1-cycle latency from eligibility to int_flag_o):
//   - S_ARB_IDLE: if global_int_en_i and eligible!=0 -> S_ARB_REQ. Latch winner; drive int_flag_o/int_cause_o next cycle.
//   - S_ARB_REQ: hold the winner stable until int_ack_i.
//     - If global_int_en_i drops, or the winner's mie bit clears, before ack: drop flags -> S_ARB_IDLE; pending kept.
//     - On int_ack_i: clear the winner's pending bit (edge sources only), flags -> 0, -> S_ARB_ACTIVE.
//   - S_ARB_ACTIVE: no requests; on mret_i -> S_ARB_IDLE. Arbitration resumes the cycle after.
// - Simultaneous events:
//   - new edge on the winner in the same cycle as int_ack_i -> bit stays pending;
//   - int_ack_i in S_ARB_IDLE/ACTIVE is ignored;
//   - mret_i outside S_ARB_ACTIVE is ignored;
//   - mret_i and int_ack_i together in S_ARB_REQ -> ack wins.
// - Level source deasserting while it is the REQ winner: the request is still held until ack, so clint never sees a
//   flag withdrawn mid-sync.
// - Reset mid-operation: all state returns to reset values next edge, regardless of FSM state.
// CONFIGURATION
// - INT_ARB_RR_EN undefined:
//   - fixed priority, lowest index wins.
// - INT_ARB_RR_EN defined:
//   - round-robin: search starts at rr pointer; pointer <= winner+1 (mod NUM_SRC) on int_ack_i;
//   - pointer reset 0.
// STRUCTURE
// - defines.v gains: S_ARB_IDLE/S_ARB_REQ/S_ARB_ACTIVE (3-bit one-hot), `INT_ARB_CAUSE_BASE default.
// - Sub-module int_prio_pick: combinational winner select.
//   - in: eligible vector, start index; out: valid, index.
//   - rotate-then-priority-encode; start tied 0 when INT_ARB_RR_EN is off.
// - Top holds capture regs, FSM, output regs.
// TESTING
// - Fixed priority, MIE=1, mie=32'h000F_0000: pulse irq_i=4'b0110.
//   -> next cycle int_flag_o=8'h02, int_cause_o=32'h8000_0011; hold until ack; after ack pending=4'b0100.
// - Continue: mret_i -> cycle after int_flag_o=8'h04, cause=32'h8000_0012.
// - No nesting: in S_ARB_ACTIVE raise irq_i[0] -> int_flag_o stays 0 until mret_i; then 8'h01.
// - Global disable: in S_ARB_REQ drop global_int_en_i -> flags 0 next cycle, pending unchanged; re-enable -> same winner.
// - Edge on ack: irq_i[0] rises in the int_ack_i cycle for source 0 -> int_pending_o[0]=1 after ack.
// - INT_ARB_RR_EN: hold irq_i=4'b1111 level, ack+mret each round -> winners 0,1,2,3,0; reset mid-REQ -> all outputs 0.

Source files
------------

// File: rtl/int_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : int_arbiter_pkg
// Brief    : Shared types, constants and helpers for the interrupt arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package int_arbiter_pkg;

    localparam int         INT_ARB_CAUSE_BASE = 16;
    localparam int         INT_BUS_W          = 8;
    localparam int         INT_IDX_W          = 3;
    localparam logic [7:0] INT_NONE           = 8'h00;

    typedef enum logic [2:0] {
        S_ARB_IDLE   = 3'b001,
        S_ARB_REQ    = 3'b010,
        S_ARB_ACTIVE = 3'b100
    } arb_state_t;

    // Interrupt mcause: bit 31 set, exception code in the low five bits.
    function automatic logic [31:0] int_cause(input int base, input logic [INT_IDX_W-1:0] idx);
        logic [4:0] code;
        code = 5'(base) + {2'b00, idx};
        return {1'b1, 26'b0, code};
    endfunction

    function automatic logic [INT_IDX_W-1:0] next_idx(input logic [INT_IDX_W-1:0] idx, input int n);
        return (idx == INT_IDX_W'(n - 1)) ? '0 : idx + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/int_arbiter_prio_pick.sv
`default_nettype none
// ============================================================================
// Module   : int_prio_pick
// Brief    : Combinational winner select: rotate eligible vector to the start
//            index, then priority-encode the lowest set bit.
// Revision : 1.0 - initial release
// ============================================================================
module int_prio_pick
    import int_arbiter_pkg::*;
#(
    parameter int NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0]   eligible,
    input  logic [INT_IDX_W-1:0] start,
    output logic                 valid,
    output logic [INT_IDX_W-1:0] index
);

    logic [2*NUM_SRC-1:0] w_dbl;
    logic [NUM_SRC-1:0]   w_rot;
    logic [INT_IDX_W-1:0] w_off;
    logic [INT_IDX_W:0]   w_sum;

    assign w_dbl = {eligible, eligible};
    assign w_rot = NUM_SRC'(w_dbl >> start);

    always_comb begin
        valid = |eligible;
        w_off = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = INT_IDX_W'(k);
            end
        end
        w_sum = {1'b0, start} + {1'b0, w_off};
        index = (w_sum >= (INT_IDX_W + 1)'(NUM_SRC)) ? INT_IDX_W'(w_sum - (INT_IDX_W + 1)'(NUM_SRC))
                                                     : INT_IDX_W'(w_sum);
    end

endmodule
`default_nettype wire

// File: rtl/int_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : int_arbiter
// Brief    : Latches interrupt lines as pending, masks with mie and offers a
//            single non-nesting request to clint. Define INT_ARB_RR_EN for
//            round-robin arbitration (fixed lowest-index priority otherwise).
// Revision : 1.0 - initial release
// ============================================================================
module int_arbiter
    import int_arbiter_pkg::*;
#(
    parameter int                 NUM_SRC    = 4,
    parameter logic [NUM_SRC-1:0] EDGE_MASK  = 4'b0001,
    parameter int                 CAUSE_BASE = INT_ARB_CAUSE_BASE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_SRC-1:0]   irq_i,
    input  logic [31:0]          csr_mie,
    input  logic                 global_int_en_i,
    input  logic                 int_ack_i,
    input  logic                 mret_i,
    output logic [INT_BUS_W-1:0] int_flag_o,
    output logic [31:0]          int_cause_o,
    output logic [NUM_SRC-1:0]   int_pending_o
);

    arb_state_t           r_state;
    logic [INT_IDX_W-1:0] r_win_idx;
    logic [NUM_SRC-1:0]   r_pending;
    logic [NUM_SRC-1:0]   r_irq_q;

    logic [NUM_SRC-1:0]   w_pending_nxt;
    logic [NUM_SRC-1:0]   w_mie_src;
    logic [NUM_SRC-1:0]   w_elig;
    logic [7:0]           w_mie_pad;
    logic                 w_ack_req;
    logic                 w_hold;
    logic                 w_pick_valid;
    logic [INT_IDX_W-1:0] w_pick_idx;
    logic [INT_IDX_W-1:0] w_start;
    logic                 w_unused_mie;

    assign w_mie_src    = csr_mie[CAUSE_BASE +: NUM_SRC];
    assign w_elig       = r_pending & w_mie_src;
    assign w_ack_req    = (r_state == S_ARB_REQ) && int_ack_i;
    assign w_hold       = (r_state == S_ARB_REQ) && !int_ack_i;
    assign w_unused_mie = ^csr_mie;
    assign int_pending_o = r_pending;

    always_comb begin
        w_mie_pad              = '0;
        w_mie_pad[NUM_SRC-1:0] = w_mie_src;
    end

    // A fresh rising edge in the ack cycle wins over the ack's clear.
    genvar gi;
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_pend
        if (EDGE_MASK[gi]) begin : g_edge
            assign w_pending_nxt[gi] = (r_pending[gi] & ~(w_ack_req && (r_win_idx == INT_IDX_W'(gi))))
                                     | (irq_i[gi] & ~r_irq_q[gi]);
        end else begin : g_level
            assign w_pending_nxt[gi] = irq_i[gi] | (w_hold && (r_win_idx == INT_IDX_W'(gi)));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
            r_irq_q   <= '0;
        end else begin
            r_pending <= w_pending_nxt;
            r_irq_q   <= irq_i;
        end
    end

`ifdef INT_ARB_RR_EN
    logic [INT_IDX_W-1:0] r_rr_ptr;
    assign w_start = r_rr_ptr;
`else
    assign w_start = '0;
`endif

    int_prio_pick #(
        .NUM_SRC (NUM_SRC)
    ) u_pick (
        .eligible (w_elig),
        .start    (w_start),
        .valid    (w_pick_valid),
        .index    (w_pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_ARB_IDLE;
            r_win_idx   <= '0;
            int_flag_o  <= INT_NONE;
            int_cause_o <= '0;
`ifdef INT_ARB_RR_EN
            r_rr_ptr    <= '0;
`endif
        end else begin
            case (r_state)
                S_ARB_IDLE: begin
                    if (global_int_en_i && w_pick_valid) begin
                        r_state     <= S_ARB_REQ;
                        r_win_idx   <= w_pick_idx;
                        int_flag_o  <= 8'd1 << w_pick_idx;
                        int_cause_o <= int_cause(CAUSE_BASE, w_pick_idx);
                    end
                end
                // Ack has priority over withdrawal: clint has already committed.
                S_ARB_REQ: begin
                    if (int_ack_i) begin
                        r_state     <= S_ARB_ACTIVE;
                        int_flag_o  <= INT_NONE;
                        int_cause_o <= '0;
`ifdef INT_ARB_RR_EN
                        r_rr_ptr    <= next_idx(r_win_idx, NUM_SRC);
`endif
                    end else if (!global_int_en_i || !w_mie_pad[r_win_idx]) begin
                        r_state     <= S_ARB_IDLE;
                        int_flag_o  <= INT_NONE;
                        int_cause_o <= '0;
                    end
                end
                S_ARB_ACTIVE: begin
                    if (mret_i) begin
                        r_state <= S_ARB_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_ARB_IDLE;
                    int_flag_o  <= INT_NONE;
                    int_cause_o <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_int_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_int_arbiter
// Brief    : Self-checking bench for int_arbiter (vector table + sequences).
// Revision : 1.0 - initial release
// ============================================================================
module tb_int_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  irq;
    logic [31:0] mie;
    logic        en;
    logic        ack;
    logic        mret;
    logic [7:0]  flag;
    logic [31:0] cause;
    logic [3:0]  pend;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    int_arbiter #(
        .NUM_SRC    (4),
        .EDGE_MASK  (4'b0001),
        .CAUSE_BASE (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .irq_i           (irq),
        .csr_mie         (mie),
        .global_int_en_i (en),
        .int_ack_i       (ack),
        .mret_i          (mret),
        .int_flag_o      (flag),
        .int_cause_o     (cause),
        .int_pending_o   (pend)
    );

    typedef struct {
        logic [3:0]  irq;
        logic [31:0] mie;
        logic        en;
        logic [7:0]  flag;
        logic [31:0] cause;
    } vec_t;

    typedef struct {
        logic [7:0]  flag;
        logic [31:0] cause;
        logic [3:0]  pend;
    } exp_t;

    vec_t vecs[8];
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        irq  = '0;
        ack  = 1'b0;
        mret = 1'b0;
        step();
        step();
        rst  = 1'b0;
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        step();
        ack = 1'b0;
    endtask

    task automatic pulse_mret();
        mret = 1'b1;
        step();
        mret = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   exp_w[5];

        vecs[0] = '{4'b0110, 32'h000F_0000, 1'b1, 8'h02, 32'h8000_0011};
        vecs[1] = '{4'b1000, 32'h000F_0000, 1'b1, 8'h08, 32'h8000_0013};
        vecs[2] = '{4'b1111, 32'h000F_0000, 1'b1, 8'h01, 32'h8000_0010};
        vecs[3] = '{4'b1110, 32'h0004_0000, 1'b1, 8'h04, 32'h8000_0012};
        vecs[4] = '{4'b1111, 32'h000F_0000, 1'b0, 8'h00, 32'h0000_0000};
        vecs[5] = '{4'b0000, 32'h000F_0000, 1'b1, 8'h00, 32'h0000_0000};
        vecs[6] = '{4'b0101, 32'h0000_0000, 1'b1, 8'h00, 32'h0000_0000};
        vecs[7] = '{4'b1100, 32'h000F_0000, 1'b1, 8'h04, 32'h8000_0012};

        en  = 1'b0;
        mie = '0;
        do_reset();
        chk("reset_flag",  32'(flag),  32'h0);
        chk("reset_cause", cause,      32'h0);
        chk("reset_pend",  32'(pend),  32'h0);

        for (int v = 0; v < 8; v++) begin
            do_reset();
            irq = vecs[v].irq;
            mie = vecs[v].mie;
            en  = vecs[v].en;
            sb.push_back('{vecs[v].flag, vecs[v].cause, vecs[v].irq});
            step();
            step();
            e = sb.pop_front();
            chk($sformatf("vec%0d_flag", v),  32'(flag), 32'(e.flag));
            chk($sformatf("vec%0d_cause", v), cause,     e.cause);
            chk($sformatf("vec%0d_pend", v),  32'(pend), 32'(e.pend));
        end

`ifndef INT_ARB_RR_EN
        do_reset();
        en  = 1'b1;
        mie = 32'h000F_0000;
        irq = 4'b0110;
        step();
        step();
        chk("first_flag",  32'(flag), 32'h02);
        chk("first_cause", cause,     32'h8000_0011);
        irq = 4'b0100;
        step();
        chk("level_held_flag", 32'(flag), 32'h02);
        chk("level_held_pend", 32'(pend), 32'h6);
        pulse_ack();
        chk("ack_flag",  32'(flag), 32'h0);
        chk("ack_cause", cause,     32'h0);
        chk("ack_pend",  32'(pend), 32'h4);
        step();
        chk("active_flag", 32'(flag), 32'h0);
        pulse_mret();
        chk("mret_idle_flag", 32'(flag), 32'h0);
        step();
        chk("second_flag",  32'(flag), 32'h04);
        chk("second_cause", cause,     32'h8000_0012);
        pulse_ack();
        chk("second_ack_pend", 32'(pend), 32'h4);
        irq = 4'b0101;
        step();
        step();
        chk("no_nest_flag", 32'(flag), 32'h0);
        chk("no_nest_pend", 32'(pend), 32'h5);
        pulse_mret();
        step();
        chk("after_mret_flag",  32'(flag), 32'h01);
        chk("after_mret_cause", cause,     32'h8000_0010);

        en = 1'b0;
        step();
        chk("gdis_flag", 32'(flag), 32'h0);
        chk("gdis_pend", 32'(pend), 32'h5);
        step();
        chk("gdis_idle_flag", 32'(flag), 32'h0);
        en = 1'b1;
        step();
        chk("gen_same_winner", 32'(flag), 32'h01);

        mie = 32'h000E_0000;
        step();
        chk("mie_drop_flag", 32'(flag), 32'h0);
        step();
        chk("mie_next_winner", 32'(flag), 32'h04);
        mie = 32'h000F_0000;
        step();
        chk("no_preempt_flag", 32'(flag), 32'h04);

        ack  = 1'b1;
        mret = 1'b1;
        step();
        ack  = 1'b0;
        mret = 1'b0;
        step();
        chk("ack_beats_mret", 32'(flag), 32'h0);
        pulse_ack();
        chk("ack_in_active_pend", 32'(pend), 32'h5);
        pulse_mret();
        step();
        chk("src0_again_flag", 32'(flag), 32'h01);

        irq = 4'b0100;
        step();
        ack = 1'b1;
        irq = 4'b0101;
        step();
        ack = 1'b0;
        chk("edge_on_ack_pend", 32'(pend), 32'h5);
        chk("edge_on_ack_flag", 32'(flag), 32'h0);
        pulse_mret();
        step();
        chk("edge_rearm_flag", 32'(flag), 32'h01);
        pulse_ack();
        chk("edge_clear_pend", 32'(pend), 32'h4);

        pulse_mret();
        step();
        chk("pre_reset_flag", 32'(flag), 32'h04);
        rst = 1'b1;
        step();
        chk("midreset_flag",  32'(flag), 32'h0);
        chk("midreset_cause", cause,     32'h0);
        chk("midreset_pend",  32'(pend), 32'h0);
        rst = 1'b0;
        step();
        step();
        chk("post_reset_flag", 32'(flag), 32'h01);
`else
        exp_w = '{0, 1, 2, 3, 0};
        do_reset();
        en  = 1'b1;
        mie = 32'h000F_0000;
        irq = 4'b1111;
        step();
        step();
        for (int r = 0; r < 5; r++) begin
            chk($sformatf("rr%0d_flag", r),  32'(flag), 32'(8'd1 << exp_w[r]));
            chk($sformatf("rr%0d_cause", r), cause,     32'h8000_0010 + 32'(exp_w[r]));
            if (r < 4) begin
                pulse_ack();
                irq[0] = 1'b0;
                step();
                irq[0] = 1'b1;
                pulse_mret();
                step();
            end
        end
        rst = 1'b1;
        step();
        chk("rr_midreset_flag",  32'(flag), 32'h0);
        chk("rr_midreset_cause", cause,     32'h0);
        chk("rr_midreset_pend",  32'(pend), 32'h0);
        rst = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
